// File: rtl/interrupt_ack_sequencer.sv
// interrupt_ack_sequencer: 8086-mode two-pulse INTA sequencer for an 8259A-style PIC.
// Freezes the winning request on the first INTA#, drives the vector on the second,
// and turns AEOI / non-specific / specific EOI events into an end_interrupt mask
// plus the priority_rotate value. All outputs are registered.
module interrupt_ack_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       interrupt_acknowledge_n,
    input  logic [7:0] interrupt_to_service,
    input  logic [7:0] highest_level_in_service,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi_config,
    input  logic       nonspecific_eoi,
    input  logic       specific_eoi,
    input  logic [2:0] eoi_level,
    input  logic       rotate_on_eoi,
    output logic       interrupt_to_cpu,
    output logic       latch_ISR,
    output logic [7:0] latched_interrupt,
    output logic [7:0] clear_interrupt_request,
    output logic [7:0] end_interrupt,
    output logic [2:0] priority_rotate,
    output logic [7:0] data_bus_out,
    output logic       data_bus_io
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK1  = 2'd1,
        WAIT2 = 2'd2,
        ACK2  = 2'd3
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       inta_prev;
    logic       spurious;

    logic       inta_fall;
    logic       inta_rise;
    logic       start_ack;
    logic       end_ack;

    logic       spurious_next;
    logic       interrupt_to_cpu_next;
    logic       latch_isr_next;
    logic [7:0] latched_next;
    logic [7:0] clear_next;
    logic [7:0] end_next;
    logic [2:0] rotate_next;
    logic [7:0] bus_out_next;
    logic       bus_io_next;

    // One-hot to binary level; the inputs are one-hot so bit order does not matter.
    function automatic logic [2:0] encode(input logic [7:0] onehot);
        logic [2:0] level;
        level = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                level = 3'(i);
            end
        end
        return level;
    endfunction

    // Next-state, edge detection and next values for every registered output.
    always_comb begin
        next_state            = state;
        inta_fall             = inta_prev & ~interrupt_acknowledge_n;
        inta_rise             = ~inta_prev & interrupt_acknowledge_n;

        case (state)
            IDLE:    if (inta_fall) next_state = ACK1;
            ACK1:    if (inta_rise) next_state = WAIT2;
            WAIT2:   if (inta_fall) next_state = ACK2;
            ACK2:    if (inta_rise) next_state = IDLE;
            default: next_state = IDLE;
        endcase

        start_ack             = (state == IDLE) && inta_fall;
        end_ack               = (state == ACK2) && inta_rise;

        latched_next          = start_ack ? interrupt_to_service : latched_interrupt;
        spurious_next         = start_ack ? (interrupt_to_service == '0) : spurious;
        latch_isr_next        = start_ack && (interrupt_to_service != '0);
        clear_next            = start_ack ? interrupt_to_service : '0;

        end_next              = '0;
        if (end_ack && auto_eoi_config && !spurious) begin
            end_next = end_next | latched_interrupt;
        end
        if (nonspecific_eoi) begin
            end_next = end_next | highest_level_in_service;
        end
        if (specific_eoi) begin
            end_next = end_next | (8'b1 << eoi_level);
        end

        // Specific EOI takes precedence over non-specific when both rotate.
        rotate_next           = priority_rotate;
        if (rotate_on_eoi) begin
            if (specific_eoi) begin
                rotate_next = eoi_level;
            end else if (nonspecific_eoi && (highest_level_in_service != '0)) begin
                rotate_next = encode(highest_level_in_service);
            end
        end

        bus_io_next           = (next_state == ACK2);
        bus_out_next          = '0;
        if (bus_io_next) begin
            bus_out_next = {vector_base, spurious_next ? 3'b111 : encode(latched_next)};
        end

        interrupt_to_cpu_next = (next_state == IDLE) && (interrupt_to_service != '0);
    end

    // State, INTA# history and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            inta_prev               <= 1'b1;
            spurious                <= 1'b0;
            interrupt_to_cpu        <= 1'b0;
            latch_ISR               <= 1'b0;
            latched_interrupt       <= '0;
            clear_interrupt_request <= '0;
            end_interrupt           <= '0;
            priority_rotate         <= 3'b111;
            data_bus_out            <= '0;
            data_bus_io             <= 1'b0;
        end else begin
            state                   <= next_state;
            inta_prev               <= interrupt_acknowledge_n;
            spurious                <= spurious_next;
            interrupt_to_cpu        <= interrupt_to_cpu_next;
            latch_ISR               <= latch_isr_next;
            latched_interrupt       <= latched_next;
            clear_interrupt_request <= clear_next;
            end_interrupt           <= end_next;
            priority_rotate         <= rotate_next;
            data_bus_out            <= bus_out_next;
            data_bus_io             <= bus_io_next;
        end
    end

endmodule

// File: doc/interrupt_ack_sequencer.md
# interrupt_ack_sequencer

Control-path stage between the priority resolver and the in-service register (ISR) of the 8259A PIC. It runs the 8086-mode two-pulse INTA sequence. On the first INTA pulse it freezes the winning request and pulses `latch_ISR`. On the second pulse it drives the interrupt vector. It also turns automatic, non-specific and specific EOI events into the one-cycle `end_interrupt` mask and the `priority_rotate` value that the ISR consumes.

## Interface
- No parameters; the design is fixed to 8 IR levels and 8086 vector mode.
- `clock` in 1: single system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `interrupt_acknowledge_n` in 1: INTA#, already synchronized to `clock`; active low.
- `interrupt_to_service` in 8: one-hot winner from the priority resolver; 0 means no request.
- `highest_level_in_service` in 8: one-hot from the ISR; used for non-specific EOI.
- `vector_base` in 5: ICW2 bits T7..T3.
- `auto_eoi_config` in 1: ICW4 AEOI bit.
- `nonspecific_eoi` in 1: one-cycle OCW2 strobe.
- `specific_eoi` in 1: one-cycle OCW2 strobe.
- `eoi_level` in 3: level used by `specific_eoi`.
- `rotate_on_eoi` in 1: qualifies either EOI strobe as a rotating EOI.
- `interrupt_to_cpu` out 1: INT output to the CPU.
- `latch_ISR` out 1: one-cycle pulse to the ISR.
- `latched_interrupt` out 8: frozen one-hot request; ISR `interrupt` input.
- `clear_interrupt_request` out 8: one-cycle pulse that clears the IRR bit.
- `end_interrupt` out 8: one-cycle EOI mask to the ISR.
- `priority_rotate` out 3: lowest-priority level, fed to the ISR and the resolver.
- `data_bus_out` out 8: vector byte.
- `data_bus_io` out 1: 1 = drive the data bus.

## Operation
- Internal register `inta_prev` holds the previous INTA#. A falling edge is `inta_prev & ~interrupt_acknowledge_n`; a rising edge is the inverse. `inta_prev` resets to 1.
- State machine:
  - IDLE -> ACK1 on a falling edge.
  - ACK1 -> WAIT2 on a rising edge.
  - WAIT2 -> ACK2 on a falling edge.
  - ACK2 -> IDLE on a rising edge.
  - All other conditions hold the current state.
- IDLE -> ACK1 transition:
  - If `interrupt_to_service` != 0: `latched_interrupt` <= `interrupt_to_service`; `latch_ISR` and `clear_interrupt_request` = `interrupt_to_service` pulse for one cycle.
  - If `interrupt_to_service` = 0 (spurious): `latched_interrupt` <= 0, `spurious` flag set, no `latch_ISR`, no clear, vector level forced to 7.
- `latched_interrupt` is frozen from ACK1 until the next IDLE->ACK1 transition. Resolver changes during the sequence are ignored.
- ACK2: `data_bus_io` = 1 and `data_bus_out` = {`vector_base`, encode(`latched_interrupt`)}, or {`vector_base`, 3'b111} if spurious. Outside ACK2, `data_bus_io` = 0 and `data_bus_out` = 0.
- ACK2 -> IDLE with `auto_eoi_config` = 1 and not spurious: `end_interrupt` = `latched_interrupt` for one cycle.
- EOI strobes, accepted in any state:
  - `nonspecific_eoi`: `end_interrupt` = `highest_level_in_service`.
  - `specific_eoi`: `end_interrupt` = 1 << `eoi_level`.
  - Both strobes together: the OR of the two masks.
  - Any coincident AEOI pulse is ORed in.
- Rotation with `rotate_on_eoi` = 1: `priority_rotate` <= level of the serviced bit.
  - Specific EOI uses `eoi_level`.
  - Non-specific EOI uses encode(`highest_level_in_service`).
  - If both strobes fire, specific wins.
  - A non-specific EOI with `highest_level_in_service` = 0 clears nothing and does not rotate.
- `interrupt_to_cpu` = 1 only in IDLE with `interrupt_to_service` != 0. It is 0 from ACK1 through ACK2.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - `interrupt_to_cpu`, `latch_ISR`, `data_bus_io` = 0.
  - `latched_interrupt`, `clear_interrupt_request`, `end_interrupt`, `data_bus_out` = 0.
  - `priority_rotate` = 3'b111.
- `latch_ISR` rises on the clock edge after the edge that samples INTA# low with `inta_prev` = 1. It lasts exactly one cycle, with `latched_interrupt` already valid in that cycle.
- The vector appears on the edge after the second falling edge is detected. It is removed on the edge after the rising edge is detected.
- The AEOI `end_interrupt` pulse coincides with `data_bus_io` dropping.
- An EOI strobe at edge N produces `end_interrupt` during cycle N+1 and updates `priority_rotate` at edge N+1.
- INTA# held low for many cycles keeps the block in ACK1 or ACK2 with no repeated pulses.
- Reset asserted mid-sequence returns the block to IDLE next edge, releases the bus, clears the latch, and sets rotate back to 7.

## Test plan
- Request in, normal sequence: `interrupt_to_service` = 8'h20, `vector_base` = 5'h11, two INTA pulses -> one-cycle `latch_ISR` with `latched_interrupt` = 8'h20, `clear_interrupt_request` = 8'h20, `data_bus_out` = 8'h8D during ACK2, `interrupt_to_cpu` 1 -> 0.
- Automatic EOI: `auto_eoi_config` = 1, request 8'h04 -> `end_interrupt` = 8'h04 for one cycle at the second INTA rise.
- Spurious request: `interrupt_to_service` = 0 at first INTA -> no `latch_ISR`, vector = {base, 111}, no `end_interrupt` even with AEOI.
- Non-specific EOI with rotation: `highest_level_in_service` = 8'h08, `nonspecific_eoi` + `rotate_on_eoi` -> `end_interrupt` = 8'h08, `priority_rotate` = 3.
- Simultaneous EOI strobes: `specific_eoi` with `eoi_level` = 6, `nonspecific_eoi` with in-service 8'h01, `rotate_on_eoi` = 1 -> `end_interrupt` = 8'h41, `priority_rotate` = 6.
- Reset mid-sequence: assert `reset` in WAIT2 -> next cycle state IDLE, `latched_interrupt` = 0, `priority_rotate` = 7; a new INTA pair then completes normally.
